// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encoding and the
// load-value clamp used wherever a value must stay inside 0..modulus-1.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values at or beyond the modulus saturate to the top count.
  function automatic logic [63:0] clamp_mod(input logic [63:0] val,
                                            input logic [63:0] modulus);
    return (val >= modulus) ? (modulus - 64'd1) : val;
  endfunction

endpackage

// File: rtl/counter_mod_updown_if.sv
// Control/status bundle of a modulo-N up/down counter; the counter is the
// slave, whoever sequences it is the master.
interface counter_mod_updown_if #(parameter int WIDTH = 4);

  logic             en;
  logic             clkEn;
  logic             up;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] count;
  logic             co;
  logic             wrap;

  modport master (output en, clkEn, up, clr, ld, ld_val,
                  input  count, co, wrap);
  modport slave  (input  en, clkEn, up, clr, ld, ld_val,
                  output count, co, wrap);

endinterface

// File: rtl/counter_mod_next.sv
// Combinational successor of a modulo-N count in either direction, plus the
// terminal-count flag for the current direction.
module counter_mod_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  always_comb begin
    tc  = 1'b0;
    nxt = count;
    if (up == DIR_DOWN) begin
      tc  = (count == '0);
      nxt = tc ? MAX : count - WIDTH'(1);
    end else begin
      tc  = (count == MAX);
      nxt = tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_mod_updown.sv
// Cascadable modulo-N up/down counter with clear, clamped parallel load,
// combinational carry/borrow out and a registered wrap pulse.
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic               clk,
  input logic               rst,
  counter_mod_updown_if.slave bus
);

  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("counter_mod_updown: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] count_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld_clamped;
  logic             tc;
  logic             step;

  counter_mod_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count (count_p0),
    .up    (bus.up),
    .nxt   (nxt),
    .tc    (tc)
  );

  assign ld_clamped = WIDTH'(clamp_mod(64'(bus.ld_val), 64'(MODULUS)));
  assign step       = bus.en & bus.clkEn & ~bus.clr & ~bus.ld;

  // Stage p0: count register and wrap flag; clr beats ld beats counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_p0 <= '0;
      wrap_p0  <= 1'b0;
    end else begin
      wrap_p0 <= step & tc;
      if (bus.clr)
        count_p0 <= '0;
      else if (bus.ld)
        count_p0 <= ld_clamped;
      else if (step)
        count_p0 <= nxt;
    end
  end

  // The carry ignores clr/ld so a downstream stage sees it in the same cycle.
  assign bus.co    = bus.en & bus.clkEn & tc;
  assign bus.count = count_p0;
  assign bus.wrap  = wrap_p0;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Bench for counter_mod_updown: MODULUS=10 vector table, corner sequences,
// randomized run against an arithmetic model, and a two-stage cascade.
module tb_counter_mod_updown;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int MC = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_mod_updown_if #(.WIDTH(W)) ifa ();
  counter_mod_updown_if #(.WIDTH(W)) ifl ();
  counter_mod_updown_if #(.WIDTH(W)) ifh ();

  counter_mod_updown #(.WIDTH(W), .MODULUS(M)) u_a (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  counter_mod_updown #(.WIDTH(W), .MODULUS(MC)) u_lo (
    .clk (clk), .rst (rst), .bus (ifl.slave));
  counter_mod_updown #(.WIDTH(W), .MODULUS(MC)) u_hi (
    .clk (clk), .rst (rst), .bus (ifh.slave));

  assign ifh.clkEn = ifl.co;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic clr, input logic ld, input logic [3:0] ldv,
                         input logic en, input logic ce, input logic up);
    ifa.clr = clr; ifa.ld = ld; ifa.ld_val = ldv;
    ifa.en = en; ifa.clkEn = ce; ifa.up = up;
  endtask

  // One clock of DUT A: inputs set at negedge, co checked before the edge,
  // count/wrap checked just after it.
  task automatic cyc_a(input string nm, input logic clr, input logic ld, input logic [3:0] ldv,
                       input logic en, input logic ce, input logic up,
                       input int ecount, input logic ewrap, input logic eco);
    @(negedge clk);
    drive_a(clr, ld, ldv, en, ce, up);
    #1 chk({nm, ".co"}, 32'(ifa.co), 32'(eco));
    @(posedge clk);
    #1;
    chk({nm, ".count"}, 32'(ifa.count), 32'(ecount));
    chk({nm, ".wrap"}, 32'(ifa.wrap), 32'(ewrap));
  endtask

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] ldv;
    logic       en;
    logic       ce;
    logic       up;
    int         ecount;
    logic       ewrap;
    logic       eco;
  } vec_t;

  vec_t tbl[16];

  // Reference model state
  int   mc;
  logic r_clr, r_ld, r_en, r_ce, r_up;
  logic [3:0] r_ldv;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 9, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 9, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 9, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1};

    rst = 1'b0;
    drive_a(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    ifl.clr = 1'b0; ifl.ld = 1'b0; ifl.ld_val = '0; ifl.en = 1'b0; ifl.clkEn = 1'b0; ifl.up = 1'b1;
    ifh.clr = 1'b0; ifh.ld = 1'b0; ifh.ld_val = '0; ifh.en = 1'b0; ifh.up = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", 32'(ifa.count), 32'd0);
    chk("reset.wrap", 32'(ifa.wrap), 32'd0);
    chk("reset.co", 32'(ifa.co), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Vector table: load/clamp, clr priority, gating, co independent of clr/ld
    for (int i = 0; i < 16; i++)
      cyc_a($sformatf("tbl%0d", i), tbl[i].clr, tbl[i].ld, tbl[i].ldv, tbl[i].en,
            tbl[i].ce, tbl[i].up, tbl[i].ecount, tbl[i].ewrap, tbl[i].eco);

    // Up wrap 0..9 -> 0 -> 1
    for (int k = 0; k <= 10; k++)
      cyc_a($sformatf("up%0d", k), 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1,
            (k + 1) % M, (k == 9), (k == 9));

    // Down wrap 1,0,9,8
    cyc_a("dn_ld", 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cyc_a("dn0", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    cyc_a("dn1", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 9, 1'b1, 1'b1);
    cyc_a("dn2", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8, 1'b0, 1'b0);

    // Asynchronous reset mid-count at 7, held through an active edge
    cyc_a("rs_ld", 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    cyc_a("rs_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async.count", 32'(ifa.count), 32'd0);
    chk("rst_async.wrap", 32'(ifa.wrap), 32'd0);
    chk("rst_async.co", 32'(ifa.co), 32'd0);
    @(posedge clk);
    #1 chk("rst_hold.count", 32'(ifa.count), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_release.count", 32'(ifa.count), 32'd1);

    // Reset clears a pending wrap pulse immediately
    cyc_a("rw_ld", 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0);
    cyc_a("rw_up", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 chk("rst_wrap.wrap", 32'(ifa.wrap), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Randomized run against an arithmetic model
    cyc_a("rnd_clr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    mc = 0;
    for (int k = 0; k < 300; k++) begin
      int   nxt;
      logic stepping, at_end, eco, ewrap;
      r_clr = ($urandom_range(0, 19) == 0);
      r_ld  = ($urandom_range(0, 9) == 0);
      r_ldv = 4'($urandom_range(0, 15));
      r_en  = ($urandom_range(0, 4) != 0);
      r_ce  = ($urandom_range(0, 4) != 0);
      r_up  = 1'($urandom_range(0, 1));
      stepping = r_en && r_ce && !r_clr && !r_ld;
      at_end   = r_up ? (mc + 1 == M) : (mc == 0);
      eco      = r_en && r_ce && at_end;
      ewrap    = stepping && at_end;
      if (r_clr)       nxt = 0;
      else if (r_ld)   nxt = (int'(r_ldv) < M) ? int'(r_ldv) : M - 1;
      else if (stepping) nxt = r_up ? (mc + 1) % M : (mc + M - 1) % M;
      else             nxt = mc;
      cyc_a($sformatf("rnd%0d", k), r_clr, r_ld, r_ldv, r_en, r_ce, r_up, nxt, ewrap, eco);
      mc = nxt;
    end
    @(negedge clk) drive_a(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Cascade of two MODULUS=16 stages counting 255 cycles from zero
    @(negedge clk);
    ifl.clr = 1'b1; ifh.clr = 1'b1;
    @(negedge clk);
    ifl.clr = 1'b0; ifh.clr = 1'b0;
    ifl.en = 1'b1; ifl.clkEn = 1'b1; ifl.up = 1'b1;
    ifh.en = 1'b1; ifh.up = 1'b1;
    #1 chk("cas_start", 32'({ifh.count, ifl.count}), 32'h00);
    repeat (255) @(posedge clk);
    #1;
    chk("cas_ff.count", 32'({ifh.count, ifl.count}), 32'hFF);
    chk("cas_ff.lo_co", 32'(ifl.co), 32'd1);
    chk("cas_ff.hi_co", 32'(ifh.co), 32'd1);
    chk("cas_ff.hi_wrap", 32'(ifh.wrap), 32'd0);
    @(posedge clk);
    #1;
    chk("cas_00.count", 32'({ifh.count, ifl.count}), 32'h00);
    chk("cas_00.hi_wrap", 32'(ifh.wrap), 32'd1);
    chk("cas_00.lo_wrap", 32'(ifl.wrap), 32'd1);
    @(posedge clk);
    #1;
    chk("cas_01.count", 32'({ifh.count, ifl.count}), 32'h01);
    chk("cas_01.hi_wrap", 32'(ifh.wrap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
